cache_arbiter: RTL and testbench

//  Downstream of the pipelined datapath's split L1 caches. Arbitrates I-cache line fills
//  and D-cache line fills/writebacks onto the single physical memory port.

---
 rtl/cache_arbiter.sv | 98 +++++++++
 tb/tb_cache_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter of split L1 line fills/writebacks onto one memory port
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   last_d;
  logic   d_pending;

  assign d_pending = d_read | d_write;

  // On a collision the client that was not granted last wins; reset leaves last_d=0 so D goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read && (!d_pending || last_d)) begin
            state  <= SERVE_I;
            last_d <= 1'b0;
          end else if (d_pending) begin
            state  <= SERVE_D;
            last_d <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_read;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // Client protocol checks: no simultaneous D read+write, no request dropped mid-transaction.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write));
  a_i_held: assert property (@(posedge clk) disable iff (!reset_n)
    (state == SERVE_I) |-> (i_read || pmem_resp));
  a_d_held: assert property (@(posedge clk) disable iff (!reset_n)
    (state == SERVE_D) |-> (d_pending || pmem_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - randomized self-checking bench for cache_arbiter
`timescale 1ns/1ps
module tb_cache_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int WIN_I = 0;
  localparam int WIN_D = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int errors = 0;
  int checks = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== '0 || pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd/wr/iresp/dresp=%b addr=%h wdata=%h, required all 0",
               {pmem_read, pmem_write, i_resp, d_resp}, pmem_address, pmem_wdata);
    end
    step();
    reset_n = 1'b1;
    d_read = 1'b1;
    d_address = 16'h2220;
    step();
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 16'h2220) begin
      errors++;
      $display("FAIL reset_pre_grant: rd/wr=%b addr=%h, required 10 2220", {pmem_read, pmem_write}, pmem_address);
    end
    step();
    reset_n = 1'b0;
    d_read = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, d_resp} !== 3'b0 || pmem_address !== '0) begin
      errors++;
      $display("FAIL reset_async: rd/wr/dresp=%b addr=%h, required 0", {pmem_read, pmem_write, d_resp}, pmem_address);
    end
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b0) begin
      errors++;
      $display("FAIL reset_next_cycle: rd/wr=%b, required 00", {pmem_read, pmem_write});
    end
    step();
    reset_n = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp} !== 2'b0) begin
      errors++;
      $display("FAIL reset_abandoned: iresp/dresp=%b, required 00", {i_resp, d_resp});
    end
    step();
    pmem_resp = 1'b0;
  endtask

  task automatic test_lone_i();
    i_read = 1'b1;
    i_address = 16'h0040;
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b1000 || pmem_address !== 16'h0040) begin
        errors++;
        $display("FAIL lone_i_wait%0d: rd/wr/iresp/dresp=%b addr=%h, required 1000 0040",
                 c, {pmem_read, pmem_write, i_resp, d_resp}, pmem_address);
      end
      step();
    end
    pmem_resp = 1'b1;
    pmem_rdata = {16{8'hA5}};
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp} !== 2'b10 || i_rdata !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL lone_i_resp: iresp/dresp=%b rdata=%h, required 10 a5..", {i_resp, d_resp}, i_rdata);
    end
    step();
    pmem_resp = 1'b0;
    i_read = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_resp} !== 3'b0) begin
      errors++;
      $display("FAIL lone_i_idle: rd/wr/iresp=%b, required 000", {pmem_read, pmem_write, i_resp});
    end
    step();
  endtask

  task automatic test_collision();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    i_read = 1'b1;
    i_address = 16'h0100;
    d_read = 1'b1;
    d_address = 16'h0200;
    step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0200) begin
      errors++;
      $display("FAIL collision_d_first: rd=%b addr=%h, required 1 0200", pmem_read, pmem_address);
    end
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp} !== 2'b01) begin
      errors++;
      $display("FAIL collision_d_resp: iresp/dresp=%b, required 01", {i_resp, d_resp});
    end
    step();
    pmem_resp = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00 || pmem_address !== '0) begin
      errors++;
      $display("FAIL collision_gap: rd/wr=%b addr=%h, required 00 0000", {pmem_read, pmem_write}, pmem_address);
    end
    step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0100) begin
      errors++;
      $display("FAIL collision_i_second: rd=%b addr=%h, required 1 0100", pmem_read, pmem_address);
    end
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp} !== 2'b10) begin
      errors++;
      $display("FAIL collision_i_resp: iresp/dresp=%b, required 10", {i_resp, d_resp});
    end
    step();
    pmem_resp = 1'b0;
    i_read = 1'b0;
    @(negedge clk);
    step();
  endtask

  task automatic test_fairness();
    int exp_seq[4] = '{WIN_D, WIN_I, WIN_D, WIN_I};
    logic [AW-1:0] exp_addr;
    i_read = 1'b1;
    i_address = 16'h0A00;
    d_read = 1'b1;
    d_address = 16'h0D00;
    step();
    for (int k = 0; k < 4; k++) begin
      exp_addr = (exp_seq[k] == WIN_I) ? 16'h0A00 : 16'h0D00;
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== exp_addr) begin
        errors++;
        $display("FAIL fairness_grant%0d: rd=%b addr=%h, required 1 %h", k, pmem_read, pmem_address, exp_addr);
      end
      step();
      pmem_resp = 1'b1;
      @(negedge clk);
      checks++;
      if ({i_resp, d_resp} !== ((exp_seq[k] == WIN_I) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fairness_resp%0d: iresp/dresp=%b, winner=%0d", k, {i_resp, d_resp}, exp_seq[k]);
      end
      step();
      pmem_resp = 1'b0;
      if (k == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
        errors++;
        $display("FAIL fairness_gap%0d: rd/wr=%b, required 00", k, {pmem_read, pmem_write});
      end
      step();
    end
  endtask

  task automatic test_writeback();
    d_write = 1'b1;
    d_address = 16'h1230;
    d_wdata = {4{32'hDEADBEEF}};
    step();
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, d_resp} !== 3'b010 || pmem_address !== 16'h1230 || pmem_wdata !== {4{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL writeback_strobe: rd/wr/dresp=%b addr=%h wdata=%h, required 010 1230 deadbeef..",
               {pmem_read, pmem_write, d_resp}, pmem_address, pmem_wdata);
    end
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp} !== 2'b01) begin
      errors++;
      $display("FAIL writeback_resp: iresp/dresp=%b, required 01", {i_resp, d_resp});
    end
    step();
    pmem_resp = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00 || pmem_wdata !== '0) begin
      errors++;
      $display("FAIL writeback_idle: rd/wr=%b wdata=%h, required 00 0", {pmem_read, pmem_write}, pmem_wdata);
    end
    step();
  endtask

  task automatic test_spurious();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      errors++;
      $display("FAIL spurious_resp: rd/wr/iresp/dresp=%b, required 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    step();
    pmem_resp = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      errors++;
      $display("FAIL spurious_after: rd/wr/iresp/dresp=%b, required 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    i_read = 1'b1;
    i_address = 16'h0777;
    step();
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0777) begin
      errors++;
      $display("FAIL spurious_still_idle: rd=%b addr=%h, required 1 0777", pmem_read, pmem_address);
    end
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (i_resp !== 1'b1) begin
      errors++;
      $display("FAIL spurious_follow_resp: iresp=%b, required 1", i_resp);
    end
    step();
    pmem_resp = 1'b0;
    i_read = 1'b0;
    @(negedge clk);
    step();
  endtask

  task automatic test_random();
    bit            i_pend = 0;
    bit            d_pend = 0;
    bit            d_is_wr = 0;
    int            last_winner = WIN_I;
    int            winner;
    int            i_wait = 0;
    int            d_wait = 0;
    int            lat;
    logic [LW-1:0] rd;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
    logic [1:0]    exp_rw;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend = 1;
        i_read = 1'b1;
        i_address = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1;
        d_is_wr = 1'($urandom_range(0, 1));
        d_read = ~d_is_wr;
        d_write = d_is_wr;
        d_address = 16'($urandom);
        d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!i_pend && !d_pend) begin
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
          errors++;
          $display("FAIL random_idle t=%0d: rd/wr=%b, required 00", t, {pmem_read, pmem_write});
        end
        continue;
      end
      if (i_pend && d_pend) winner = (last_winner == WIN_D) ? WIN_I : WIN_D;
      else winner = i_pend ? WIN_I : WIN_D;
      exp_addr  = (winner == WIN_I) ? i_address : d_address;
      exp_wdata = (winner == WIN_I) ? '0 : d_wdata;
      exp_rw    = (winner == WIN_I) ? 2'b10 : {~d_is_wr, d_is_wr};
      lat = $urandom_range(0, 3);
      step();
      for (int c = 0; c <= lat; c++) begin
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write} !== exp_rw || pmem_address !== exp_addr || pmem_wdata !== exp_wdata ||
            {i_resp, d_resp} !== 2'b00) begin
          errors++;
          $display("FAIL random_grant t=%0d c=%0d: rd/wr=%b addr=%h resp=%b, required %b %h 00",
                   t, c, {pmem_read, pmem_write}, pmem_address, {i_resp, d_resp}, exp_rw, exp_addr);
        end
        step();
      end
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      pmem_resp = 1'b1;
      pmem_rdata = rd;
      @(negedge clk);
      checks++;
      if ({i_resp, d_resp} !== ((winner == WIN_I) ? 2'b10 : 2'b01) ||
          ((winner == WIN_I) ? i_rdata : d_rdata) !== rd) begin
        errors++;
        $display("FAIL random_resp t=%0d: iresp/dresp=%b winner=%0d rdata_ok=%0d",
                 t, {i_resp, d_resp}, winner, ((winner == WIN_I) ? i_rdata : d_rdata) === rd);
      end
      step();
      pmem_resp = 1'b0;
      last_winner = winner;
      if (winner == WIN_I) begin
        i_pend = 0;
        i_read = 1'b0;
        i_wait = 0;
        if (d_pend) d_wait++;
      end else begin
        d_pend = 0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_wait = 0;
        if (i_pend) i_wait++;
      end
      checks++;
      if (i_wait > 1 || d_wait > 1) begin
        errors++;
        $display("FAIL random_starvation t=%0d: i_wait=%0d d_wait=%0d, required <=1", t, i_wait, d_wait);
      end
      @(negedge clk);
      checks++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
        errors++;
        $display("FAIL random_gap t=%0d: rd/wr/iresp/dresp=%b, required 0000", t, {pmem_read, pmem_write, i_resp, d_resp});
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_collision();
    test_fairness();
    test_writeback();
    test_spurious();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
